// File: rtl/johnson_phase_decoder_8_bit.sv
// Decodes a falling-edge-updated 8-bit Johnson code into a 0..15 phase index, tracks
// revolutions and flags illegal codes or phase skips. Two-stage rising-edge pipeline.
module johnson_phase_decoder_8_bit (
    input  logic       Clk_In,
    input  logic       Reset_N_In,
    input  logic       Enable_In,
    input  logic [7:0] Johnson_Count_In,
    input  logic       Counter_Running_Flag_In,
    input  logic       Clear_Error_In,
    output logic [3:0] Phase_Index_Out,
    output logic       Phase_Valid_Out,
    output logic       Wrap_Pulse_Out,
    output logic [7:0] Revolution_Count_Out,
    output logic       Illegal_Code_Flag_Out,
    output logic       Skip_Error_Flag_Out
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t     state_q, state_d;
    logic [7:0] code1_q, prevCode_q;
    logic       run1_q;
    logic [3:0] phase_q, phase_d;
    logic       valid_q, valid_d;
    logic       wrap_q, wrap_d;
    logic [7:0] revCount_q, revCount_d;
    logic       illegal_q, illegal_d;
    logic       skip_q, skip_d;

    logic [3:0] popCount, decIdx;
    logic       codeLegal, codeChanged, illegalHit, skipHit;

    always_comb begin
        popCount = 4'd0;
        for (int i = 0; i < 8; i++) begin
            popCount = popCount + {3'b000, code1_q[i]};
        end
    end

    // Codes with bit0 clear (other than 00) sit in the falling half: index = 16 - popcount.
    assign decIdx = (code1_q[0] || (code1_q == 8'h00)) ? popCount : (4'd0 - popCount);

    always_comb begin
        case (code1_q)
            8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80: codeLegal = 1'b1;
            default:                                                codeLegal = 1'b0;
        endcase
    end

    assign codeChanged = (code1_q != prevCode_q);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        valid_d    = valid_q;
        wrap_d     = 1'b0;
        revCount_d = revCount_q;
        illegalHit = 1'b0;
        skipHit    = 1'b0;

        if (!codeLegal) begin
            illegalHit = 1'b1;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    phase_d = decIdx;
                    valid_d = 1'b1;
                    state_d = TRACK;
                end
                TRACK: begin
                    if (codeChanged) begin
                        phase_d = decIdx;
                        if (run1_q) begin
                            if (decIdx != phase_q + 4'd1) begin
                                skipHit = 1'b1;
                            end else if (phase_q == 4'd15) begin
                                wrap_d     = 1'b1;
                                revCount_d = revCount_q + 8'd1;
                            end
                        end
                    end
                end
                FAULT: begin
                    phase_d = decIdx;
                    valid_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        // A fresh error outranks a coincident clear.
        illegal_d = illegalHit | (illegal_q & ~Clear_Error_In);
        skip_d    = skipHit | (skip_q & ~Clear_Error_In);
        if (illegalHit || skipHit) begin
            state_d = FAULT;
        end else if (Clear_Error_In) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            code1_q    <= 8'h00;
            run1_q     <= 1'b0;
            prevCode_q <= 8'h00;
            state_q    <= IDLE;
            phase_q    <= 4'd0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            revCount_q <= 8'h00;
            illegal_q  <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            code1_q    <= Johnson_Count_In;
            run1_q     <= Counter_Running_Flag_In;
            prevCode_q <= code1_q;
            state_q    <= state_d;
            phase_q    <= phase_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            revCount_q <= revCount_d;
            illegal_q  <= illegal_d;
            skip_q     <= skip_d;
        end
    end

    assign Phase_Index_Out       = Enable_In ? phase_q    : 4'bzzzz;
    assign Phase_Valid_Out       = Enable_In ? valid_q    : 1'bz;
    assign Wrap_Pulse_Out        = Enable_In ? wrap_q     : 1'bz;
    assign Revolution_Count_Out  = Enable_In ? revCount_q : 8'bzzzzzzzz;
    assign Illegal_Code_Flag_Out = Enable_In ? illegal_q  : 1'bz;
    assign Skip_Error_Flag_Out   = Enable_In ? skip_q     : 1'bz;

endmodule

// File: tb/tb_johnson_phase_decoder_8_bit.sv
// Self-checking bench for johnson_phase_decoder_8_bit: directed scenarios plus a
// randomized run compared against a table-driven behavioural model.
module tb_johnson_phase_decoder_8_bit;

    logic       Clk_In = 1'b0;
    logic       Reset_N_In;
    logic       Enable_In;
    logic [7:0] Johnson_Count_In;
    logic       Counter_Running_Flag_In;
    logic       Clear_Error_In;
    wire  [3:0] Phase_Index_Out;
    wire        Phase_Valid_Out;
    wire        Wrap_Pulse_Out;
    wire  [7:0] Revolution_Count_Out;
    wire        Illegal_Code_Flag_Out;
    wire        Skip_Error_Flag_Out;

    johnson_phase_decoder_8_bit dut (
        .Clk_In(Clk_In),
        .Reset_N_In(Reset_N_In),
        .Enable_In(Enable_In),
        .Johnson_Count_In(Johnson_Count_In),
        .Counter_Running_Flag_In(Counter_Running_Flag_In),
        .Clear_Error_In(Clear_Error_In),
        .Phase_Index_Out(Phase_Index_Out),
        .Phase_Valid_Out(Phase_Valid_Out),
        .Wrap_Pulse_Out(Wrap_Pulse_Out),
        .Revolution_Count_Out(Revolution_Count_Out),
        .Illegal_Code_Flag_Out(Illegal_Code_Flag_Out),
        .Skip_Error_Flag_Out(Skip_Error_Flag_Out)
    );

    always #5 Clk_In = ~Clk_In;

    localparam int M_IDLE  = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAULT = 2;

    // Phase n is the table position of its code.
    logic [7:0] codeTable [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                   8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    int checks;
    int errors;

    logic [7:0] mS1Code, mPrev;
    bit         mS1Run, mValid, mWrap, mIll, mSkip;
    int         mMode, mPhase, mRev;

    function automatic int lookupPhase(input logic [7:0] c);
        for (int i = 0; i < 16; i++) begin
            if (codeTable[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mS1Code = 8'h00; mS1Run = 1'b0; mPrev = 8'h00; mMode = M_IDLE;
        mPhase = 0; mValid = 1'b0; mWrap = 1'b0; mRev = 0; mIll = 1'b0; mSkip = 1'b0;
    endtask

    task automatic modelEdge(input bit clr);
        int idx;
        bit illHit, skipHit;
        idx = lookupPhase(mS1Code);
        illHit = 1'b0; skipHit = 1'b0; mWrap = 1'b0;
        if (idx < 0) begin
            illHit = 1'b1;
            mValid = 1'b0;
        end else if (mMode == M_IDLE) begin
            mPhase = idx; mValid = 1'b1; mMode = M_TRACK;
        end else if (mMode == M_TRACK) begin
            if (mS1Code != mPrev) begin
                if (mS1Run && idx != (mPhase + 1) % 16) begin
                    skipHit = 1'b1;
                end else if (mS1Run && mPhase == 15) begin
                    mWrap = 1'b1;
                    mRev = (mRev + 1) % 256;
                end
                mPhase = idx;
            end
        end else begin
            mPhase = idx; mValid = 1'b1;
        end
        mPrev = mS1Code;
        mIll  = illHit  || (mIll  && !clr);
        mSkip = skipHit || (mSkip && !clr);
        if (illHit || skipHit) mMode = M_FAULT;
        else if (clr)          mMode = M_IDLE;
    endtask

    task automatic cycle(input logic [7:0] c, input bit r, input bit clr);
        @(negedge Clk_In);
        Johnson_Count_In = c;
        Counter_Running_Flag_In = r;
        Clear_Error_In = clr;
        @(posedge Clk_In);
        modelEdge(clr);
        mS1Code = c;
        mS1Run  = r;
        #1;
    endtask

    task automatic doReset();
        @(negedge Clk_In);
        Reset_N_In = 1'b0;
        Johnson_Count_In = 8'h00;
        Counter_Running_Flag_In = 1'b0;
        Clear_Error_In = 1'b0;
        modelReset();
        repeat (2) @(posedge Clk_In);
        @(negedge Clk_In);
        Reset_N_In = 1'b1;
        @(posedge Clk_In);
        modelEdge(1'b0);
        mS1Code = 8'h00;
        mS1Run  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2 Reset_N_In = 1'b0;
        #1;
        checks++; if (Phase_Index_Out !== 4'd0) begin errors++; $display("[TB] FAIL reset_phase got %0h want 0", Phase_Index_Out); end
        checks++; if (Phase_Valid_Out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", Phase_Valid_Out); end
        checks++; if (Wrap_Pulse_Out !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap got %0b want 0", Wrap_Pulse_Out); end
        checks++; if (Revolution_Count_Out !== 8'h00) begin errors++; $display("[TB] FAIL reset_rev got %0h want 0", Revolution_Count_Out); end
        checks++; if (Illegal_Code_Flag_Out !== 1'b0) begin errors++; $display("[TB] FAIL reset_ill got %0b want 0", Illegal_Code_Flag_Out); end
        checks++; if (Skip_Error_Flag_Out !== 1'b0) begin errors++; $display("[TB] FAIL reset_skip got %0b want 0", Skip_Error_Flag_Out); end
        doReset();
        checks++; if (Phase_Valid_Out !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_valid got %0b want 1", Phase_Valid_Out); end
        checks++; if (Phase_Index_Out !== 4'd0) begin errors++; $display("[TB] FAIL post_reset_phase got %0h want 0", Phase_Index_Out); end
    endtask

    task automatic test_sweep();
        int wraps, k;
        doReset();
        wraps = 0; k = 0;
        for (int rev = 0; rev < 2; rev++) begin
            for (int p = 1; p <= 16; p++) begin
                cycle(codeTable[p % 16], 1'b1, 1'b0);
                k++;
                if (Wrap_Pulse_Out === 1'b1) wraps++;
                checks++;
                if (Phase_Index_Out !== 4'((k - 1) % 16)) begin
                    errors++; $display("[TB] FAIL sweep_phase step %0d got %0d want %0d", k, Phase_Index_Out, (k - 1) % 16);
                end
            end
        end
        cycle(8'h00, 1'b1, 1'b0);
        if (Wrap_Pulse_Out === 1'b1) wraps++;
        checks++; if (wraps != 2) begin errors++; $display("[TB] FAIL sweep_wraps got %0d want 2", wraps); end
        checks++; if (Revolution_Count_Out !== 8'h02) begin errors++; $display("[TB] FAIL sweep_rev got %0h want 2", Revolution_Count_Out); end
        checks++; if (Phase_Index_Out !== 4'd0) begin errors++; $display("[TB] FAIL sweep_final_phase got %0d want 0", Phase_Index_Out); end
        checks++; if ({Illegal_Code_Flag_Out, Skip_Error_Flag_Out} !== 2'b00) begin
            errors++; $display("[TB] FAIL sweep_flags got %0b%0b want 00", Illegal_Code_Flag_Out, Skip_Error_Flag_Out);
        end
    endtask

    task automatic test_illegal();
        doReset();
        cycle(8'h01, 1'b1, 1'b0); cycle(8'h03, 1'b1, 1'b0); cycle(8'h07, 1'b1, 1'b0); cycle(8'h07, 1'b1, 1'b0);
        cycle(8'h5A, 1'b1, 1'b0); cycle(8'h5A, 1'b1, 1'b0);
        checks++; if (Illegal_Code_Flag_Out !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag got %0b want 1", Illegal_Code_Flag_Out); end
        checks++; if (Phase_Valid_Out !== 1'b0) begin errors++; $display("[TB] FAIL illegal_valid got %0b want 0", Phase_Valid_Out); end
        checks++; if (Phase_Index_Out !== 4'd3) begin errors++; $display("[TB] FAIL illegal_phase_hold got %0d want 3", Phase_Index_Out); end
        cycle(8'h07, 1'b1, 1'b0);
        cycle(8'h07, 1'b1, 1'b1);
        checks++; if (Illegal_Code_Flag_Out !== 1'b0) begin errors++; $display("[TB] FAIL illegal_clear got %0b want 0", Illegal_Code_Flag_Out); end
        checks++; if (Phase_Valid_Out !== 1'b1) begin errors++; $display("[TB] FAIL illegal_clear_valid got %0b want 1", Phase_Valid_Out); end
        cycle(8'h0F, 1'b1, 1'b0); cycle(8'h1F, 1'b1, 1'b0);
        checks++; if (Phase_Index_Out !== 4'd4 || Skip_Error_Flag_Out !== 1'b0) begin
            errors++; $display("[TB] FAIL illegal_resume got phase %0d skip %0b want 4 0", Phase_Index_Out, Skip_Error_Flag_Out);
        end
    endtask

    task automatic test_skip();
        logic [7:0] tail [12] = '{8'h7F, 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01, 8'h01};
        int wraps;
        doReset();
        cycle(8'h01, 1'b1, 1'b0); cycle(8'h03, 1'b1, 1'b0); cycle(8'h07, 1'b1, 1'b0);
        cycle(8'h3F, 1'b1, 1'b0); cycle(8'h3F, 1'b1, 1'b0);
        checks++; if (Skip_Error_Flag_Out !== 1'b1) begin errors++; $display("[TB] FAIL skip_flag got %0b want 1", Skip_Error_Flag_Out); end
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(tail[i], 1'b1, 1'b0);
            if (Wrap_Pulse_Out !== 1'b0) wraps++;
        end
        checks++; if (wraps != 0) begin errors++; $display("[TB] FAIL skip_fault_wraps got %0d want 0", wraps); end
        checks++; if (Revolution_Count_Out !== 8'h00) begin errors++; $display("[TB] FAIL skip_fault_rev got %0h want 0", Revolution_Count_Out); end
        checks++; if (Skip_Error_Flag_Out !== 1'b1) begin errors++; $display("[TB] FAIL skip_sticky got %0b want 1", Skip_Error_Flag_Out); end
        cycle(8'h01, 1'b1, 1'b1);
        checks++; if (Skip_Error_Flag_Out !== 1'b0) begin errors++; $display("[TB] FAIL skip_clear got %0b want 0", Skip_Error_Flag_Out); end
    endtask

    task automatic test_resync();
        doReset();
        for (int p = 1; p <= 6; p++) cycle(codeTable[p], 1'b1, 1'b0);
        cycle(8'h3F, 1'b0, 1'b0);
        cycle(8'h01, 1'b0, 1'b0);
        cycle(8'h01, 1'b0, 1'b0);
        checks++; if (Phase_Index_Out !== 4'd1) begin errors++; $display("[TB] FAIL resync_phase got %0d want 1", Phase_Index_Out); end
        checks++; if (Skip_Error_Flag_Out !== 1'b0) begin errors++; $display("[TB] FAIL resync_skip got %0b want 0", Skip_Error_Flag_Out); end
        checks++; if (Wrap_Pulse_Out !== 1'b0 || Revolution_Count_Out !== 8'h00) begin
            errors++; $display("[TB] FAIL resync_wrap got wrap %0b rev %0h want 0 0", Wrap_Pulse_Out, Revolution_Count_Out);
        end
    endtask

    task automatic test_simultaneous();
        doReset();
        cycle(8'h01, 1'b1, 1'b0); cycle(8'h03, 1'b1, 1'b0);
        cycle(8'h81, 1'b1, 1'b1); cycle(8'h81, 1'b1, 1'b1);
        checks++; if (Illegal_Code_Flag_Out !== 1'b1) begin errors++; $display("[TB] FAIL simul_illegal got %0b want 1", Illegal_Code_Flag_Out); end
        checks++; if (Phase_Valid_Out !== 1'b0) begin errors++; $display("[TB] FAIL simul_valid got %0b want 0", Phase_Valid_Out); end
        cycle(8'h03, 1'b1, 1'b0); cycle(8'h03, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        doReset();
        for (int k = 1; k <= 88; k++) cycle(codeTable[k % 16], 1'b1, 1'b0);
        checks++; if (Revolution_Count_Out !== 8'h05) begin errors++; $display("[TB] FAIL mid_rev_before got %0h want 5", Revolution_Count_Out); end
        #2 Reset_N_In = 1'b0;
        #1;
        checks++; if (Revolution_Count_Out !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_rev got %0h want 0", Revolution_Count_Out); end
        checks++; if (Phase_Index_Out !== 4'd0 || Phase_Valid_Out !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset_phase got %0d valid %0b want 0 0", Phase_Index_Out, Phase_Valid_Out);
        end
        checks++; if ({Wrap_Pulse_Out, Illegal_Code_Flag_Out, Skip_Error_Flag_Out} !== 3'b000) begin
            errors++; $display("[TB] FAIL mid_reset_misc got %b want 000", {Wrap_Pulse_Out, Illegal_Code_Flag_Out, Skip_Error_Flag_Out});
        end
        doReset();
    endtask

    task automatic test_enable();
        doReset();
        for (int k = 1; k <= 14; k++) cycle(codeTable[k], 1'b1, 1'b0);
        Enable_In = 1'b0;
        for (int k = 15; k <= 19; k++) begin
            cycle(codeTable[k % 16], 1'b1, 1'b0);
            checks++;
            if (!(Phase_Index_Out === 4'bzzzz || Phase_Index_Out === 4'b0000)) begin
                errors++; $display("[TB] FAIL disabled_phase got %b want z", Phase_Index_Out);
            end
            checks++;
            if (!(Phase_Valid_Out === 1'bz || Phase_Valid_Out === 1'b0)) begin
                errors++; $display("[TB] FAIL disabled_valid got %b want z", Phase_Valid_Out);
            end
        end
        checks++;
        if (!(Revolution_Count_Out === 8'bzzzzzzzz || Revolution_Count_Out === 8'h00)) begin
            errors++; $display("[TB] FAIL disabled_rev got %b want z", Revolution_Count_Out);
        end
        Enable_In = 1'b1;
        #1;
        checks++; if (Revolution_Count_Out !== 8'h01) begin errors++; $display("[TB] FAIL enable_rev got %0h want 1", Revolution_Count_Out); end
        checks++; if (Phase_Index_Out !== 4'd2) begin errors++; $display("[TB] FAIL enable_phase got %0d want 2", Phase_Index_Out); end
    endtask

    task automatic test_random();
        int sel, drvPhase, idx;
        logic [7:0] code;
        bit run, clr;
        doReset();
        drvPhase = 0;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 99);
            run = 1'b1;
            clr = ($urandom_range(0, 24) == 0);
            if (sel < 70) begin
                drvPhase = (drvPhase + 1) % 16;
                code = codeTable[drvPhase];
            end else if (sel < 80) begin
                code = codeTable[drvPhase];
            end else if (sel < 90) begin
                drvPhase = $urandom_range(0, 15);
                code = codeTable[drvPhase];
                run = 1'($urandom_range(0, 1));
            end else begin
                code = 8'($urandom_range(0, 255));
                idx = lookupPhase(code);
                if (idx >= 0) drvPhase = idx;
            end
            cycle(code, run, clr);
            checks++; if (Phase_Index_Out !== 4'(mPhase)) begin errors++; $display("[TB] FAIL rand_phase n=%0d got %0d want %0d", n, Phase_Index_Out, mPhase); end
            checks++; if (Phase_Valid_Out !== mValid) begin errors++; $display("[TB] FAIL rand_valid n=%0d got %0b want %0b", n, Phase_Valid_Out, mValid); end
            checks++; if (Wrap_Pulse_Out !== mWrap) begin errors++; $display("[TB] FAIL rand_wrap n=%0d got %0b want %0b", n, Wrap_Pulse_Out, mWrap); end
            checks++; if (Revolution_Count_Out !== 8'(mRev)) begin errors++; $display("[TB] FAIL rand_rev n=%0d got %0h want %0h", n, Revolution_Count_Out, mRev); end
            checks++; if (Illegal_Code_Flag_Out !== mIll) begin errors++; $display("[TB] FAIL rand_ill n=%0d got %0b want %0b", n, Illegal_Code_Flag_Out, mIll); end
            checks++; if (Skip_Error_Flag_Out !== mSkip) begin errors++; $display("[TB] FAIL rand_skip n=%0d got %0b want %0b", n, Skip_Error_Flag_Out, mSkip); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Enable_In = 1'b1;
        Reset_N_In = 1'b1;
        Johnson_Count_In = 8'h00;
        Counter_Running_Flag_In = 1'b0;
        Clear_Error_In = 1'b0;
        modelReset();
        $display("[TB] starting johnson_phase_decoder_8_bit bench");
        test_reset();
        test_sweep();
        test_illegal();
        test_skip();
        test_resync();
        test_simultaneous();
        test_reset_mid();
        test_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder_8_bit.md
JOHNSON_PHASE_DECODER_8_BIT -- requirements
Module: johnson_phase_decoder_8_bit

Interface
REQ-001 SHALL have port Clk_In, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port Reset_N_In, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Enable_In, input, 1 bit: when high, outputs are driven; when low, all outputs are high-Z and internal state keeps running.
REQ-004 SHALL have port Johnson_Count_In, input, 8 bits: code from the upstream 8-bit Johnson counter, which updates on the falling edge.
REQ-005 SHALL have port Counter_Running_Flag_In, input, 1 bit: running flag from the upstream counter.
REQ-006 SHALL have port Clear_Error_In, input, 1 bit: synchronous clear of the error flags and of the FAULT state.
REQ-007 SHALL have port Phase_Index_Out, output, 4 bits: decoded phase 0..15.
REQ-008 SHALL have port Phase_Valid_Out, output, 1 bit: Phase_Index_Out holds a legal decoded code.
REQ-009 SHALL have port Wrap_Pulse_Out, output, 1 bit: one-cycle pulse on a 15->0 phase step.
REQ-010 SHALL have port Revolution_Count_Out, output, 8 bits: count of completed revolutions, wrapping at 8 bits.
REQ-011 SHALL have port Illegal_Code_Flag_Out, output, 1 bit: sticky flag, a non-Johnson code was seen.
REQ-012 SHALL have port Skip_Error_Flag_Out, output, 1 bit: sticky flag, a phase step other than +1 occurred while running.

Function
REQ-013 SHALL register Johnson_Count_In and Counter_Running_Flag_In on each rising edge (stage 1), giving half-cycle setup margin after the upstream falling-edge update.
REQ-014 SHALL decode the stage-1 code and register the results (stage 2); latency from input change to outputs is exactly 2 rising edges.
REQ-015 SHALL treat exactly 16 codes as legal, with this phase mapping:
 - 00->0, 01->1, 03->2, 07->3, 0F->4, 1F->5, 3F->6, 7F->7, FF->8
 - FE->9, FC->10, F8->11, F0->12, E0->13, C0->14, 80->15
REQ-016 SHALL compute the phase as follows: bit0=1 or code=00 gives index = popcount; otherwise index = 16 - popcount; legality is checked by exact match against the 16 codes.
REQ-017 SHALL, on an illegal code: set Illegal_Code_Flag_Out, clear Phase_Valid_Out, hold Phase_Index_Out at its last legal value, and enter FAULT.
REQ-018 SHALL implement an FSM with states IDLE, TRACK and FAULT; the state is reset to IDLE.
REQ-019 SHALL, in IDLE, on a legal code: load the index, set Phase_Valid_Out and go to TRACK, with no step check.
REQ-020 SHALL, in TRACK, on a code change with running=1: require new index = (old + 1) mod 16; otherwise set Skip_Error_Flag_Out and go to FAULT.
REQ-021 SHALL, in TRACK, on a code change with running=0 (upstream reset or resync): load the new index with no step check and no wrap pulse.
REQ-022 SHALL, in TRACK, on an unchanged code: hold all outputs, with Wrap_Pulse_Out low.
REQ-023 SHALL, on a legal 15->0 step in TRACK: assert Wrap_Pulse_Out for exactly 1 cycle and increment Revolution_Count_Out (FF wraps to 00).
REQ-024 SHALL, in FAULT: keep decoding Phase_Index_Out/Phase_Valid_Out, generate no wrap pulses, freeze Revolution_Count_Out, and perform no step checks.
REQ-025 SHALL, on Clear_Error_In in any state: clear both flags and go to IDLE on the next edge.
REQ-026 SHALL, when Clear_Error_In coincides with a new illegal code or skip, give the error priority: the flag is set and the state is FAULT.
REQ-027 SHALL, when an illegal code occurs while running=0: set Illegal_Code_Flag_Out and go to FAULT regardless of the running flag.

Reset
REQ-028 SHALL, while Reset_N_In=0, immediately and asynchronously force:
 - Phase_Index_Out=0, Phase_Valid_Out=0, Wrap_Pulse_Out=0, Revolution_Count_Out=00
 - both flags=0, both pipeline stages=0, FSM=IDLE
REQ-029 SHALL resume after reset deassertion with 2-edge latency; a reset asserted mid-revolution discards the revolution count.

Verification
REQ-030 SHALL be verified by a free-running sweep: reset, then running=1 stepping 01..80,00 over 2 revolutions -> phases 1..15,0 in order; Wrap_Pulse_Out pulses twice; Revolution_Count_Out=02; flags=0.
REQ-031 SHALL be verified by an illegal code: inject 0x5A in TRACK -> after 2 edges Illegal_Code_Flag_Out=1, Phase_Valid_Out=0, phase held; Clear_Error_In -> flags 0, IDLE.
REQ-032 SHALL be verified by a skip: running=1, 07 then 3F -> Skip_Error_Flag_Out=1, FSM=FAULT, no wrap pulses until cleared.
REQ-033 SHALL be verified by a resync: running=0, 3F then 01 -> phase=1, no skip, no wrap, count unchanged.
REQ-034 SHALL be verified by a simultaneous event: Clear_Error_In=1 in the same cycle as illegal code 0x81 -> Illegal_Code_Flag_Out=1 afterwards.
REQ-035 SHALL be verified by reset and enable checks: Reset_N_In low mid-revolution (count=05) -> all outputs 0 at once; Enable_In=0 -> all outputs Z, and counting continues internally.
